// File: rtl/dcache_responder_if.sv
// Bus bundle for the data-cache responder: memory-stage request/response
// signals plus the DRAM line port.
interface dcache_responder_if;
  // memory-stage request side
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         read_enable;
  logic         write_enable;
  logic         vec_mode;
  logic [3:0]   vec_mask;
  logic [127:0] vec_wdata;
  logic [31:0]  rdata;
  logic [127:0] vec_rdata;
  logic         miss;
  // DRAM line port
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  // environment view: memory stage and DRAM
  modport master (
    output addr, wdata, read_enable, write_enable, vec_mode, vec_mask, vec_wdata,
    input  rdata, vec_rdata, miss,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

  // cache view
  modport slave (
    input  addr, wdata, read_enable, write_enable, vec_mode, vec_mask, vec_wdata,
    output rdata, vec_rdata, miss,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with 128-bit lines.
// One line buffer (r_rd_line/r_rd_tag) serves as hit data, writeback victim
// and refilled line for the RESPOND cycle.
module dcache_responder #(
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned ADDR_W  = 26
) (
  input  logic          clk,
  input  logic          rstn,
  dcache_responder_if.slave bus
);
  localparam int unsigned TAG_W  = ADDR_W - 4 - INDEX_W;
  localparam int unsigned NLINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_t;

  state_t r_state, w_next;

  // storage
  logic [127:0]       r_data_mem [NLINES];
  logic [TAG_W-1:0]   r_tag_mem  [NLINES];
  logic [NLINES-1:0]  r_valid;
  logic [NLINES-1:0]  r_dirty;

  // held request
  logic [TAG_W-1:0]   r_tag;
  logic [INDEX_W-1:0] r_idx;
  logic [1:0]         r_word;
  logic [31:0]        r_wdata;
  logic               r_vec;
  logic [3:0]         r_mask;
  logic [127:0]       r_vwdata;
  logic               r_is_write;

  // line buffer and held load outputs
  logic [TAG_W-1:0]   r_rd_tag;
  logic [127:0]       r_rd_line;
  logic [31:0]        r_last_rdata;
  logic [127:0]       r_last_vec;

  logic               w_req;
  logic [INDEX_W-1:0] w_in_idx;
  logic [TAG_W-1:0]   w_in_tag;
  logic               w_hit;
  logic               w_accept;
  logic               w_wr_en;
  logic [127:0]       w_wr_line;
  logic [127:0]       w_merged_hit;
  logic [127:0]       w_merged_fill;
  logic               w_load;
  logic [31:0]        w_word_out;
  logic               w_unused_bits;

  assign w_req    = bus.read_enable | bus.write_enable;
  assign w_in_idx = bus.addr[4 +: INDEX_W];
  assign w_in_tag = bus.addr[4 + INDEX_W +: TAG_W];
  assign w_unused_bits = ^{bus.addr[1:0], bus.addr[31:ADDR_W]};

  assign w_hit = r_valid[r_idx] && (r_rd_tag == r_tag);

  // apply the held store (scalar word or masked vector words) onto a line
  function automatic logic [127:0] f_merge(
    input logic [127:0] line,
    input logic         vec,
    input logic [3:0]   mask,
    input logic [127:0] vdata,
    input logic [31:0]  sdata,
    input logic [1:0]   word
  );
    logic [127:0] res;
    res = line;
    for (int unsigned i = 0; i < 4; i++) begin
      if (vec) begin
        if (mask[i]) res[32*i +: 32] = vdata[32*i +: 32];
      end else if (word == i[1:0]) begin
        res[32*i +: 32] = sdata;
      end
    end
    return res;
  endfunction

  assign w_merged_hit  = f_merge(r_rd_line, r_vec, r_mask, r_vwdata, r_wdata, r_word);
  assign w_merged_fill = r_is_write ? f_merge(bus.mem_rdata, r_vec, r_mask, r_vwdata, r_wdata, r_word)
                                    : bus.mem_rdata;

  // next-state, array write port, and DRAM/stall outputs
  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_wr_en       = 1'b0;
    w_wr_line     = w_merged_hit;
    w_load        = 1'b0;
    bus.miss      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        w_accept = w_req;
        if (w_req) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          w_accept = w_req;
          w_wr_en  = r_is_write;
          w_load   = !r_is_write;
          w_next   = w_req ? S_COMPARE : S_IDLE;
        end else begin
          bus.miss = 1'b1;
          w_next   = (r_valid[r_idx] && r_dirty[r_idx]) ? S_WRITEBACK : S_REFILL;
        end
      end
      S_WRITEBACK: begin
        bus.miss      = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {{(32-ADDR_W){1'b0}}, r_rd_tag, r_idx, 4'b0};
        bus.mem_wdata = r_rd_line;
        if (bus.mem_ack) w_next = S_REFILL;
      end
      S_REFILL: begin
        bus.miss     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {{(32-ADDR_W){1'b0}}, r_tag, r_idx, 4'b0};
        w_wr_line    = w_merged_fill;
        if (bus.mem_ack) begin
          w_wr_en = 1'b1;
          w_next  = S_RESPOND;
        end
      end
      S_RESPOND: begin
        w_load   = !r_is_write;
        w_accept = w_req;
        w_next   = w_req ? S_COMPARE : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_word_out    = r_rd_line[{r_word, 5'd0} +: 32];
  assign bus.rdata     = w_load ? w_word_out : r_last_rdata;
  assign bus.vec_rdata = w_load ? r_rd_line  : r_last_vec;

  // data/tag arrays: single write port at the held index
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_data_mem[r_idx] <= w_wr_line;
      r_tag_mem[r_idx]  <= r_tag;
    end
  end

  // state, request capture, synchronous array read, valid/dirty, held outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_wdata      <= '0;
      r_vec        <= 1'b0;
      r_mask       <= '0;
      r_vwdata     <= '0;
      r_is_write   <= 1'b0;
      r_rd_tag     <= '0;
      r_rd_line    <= '0;
      r_last_rdata <= '0;
      r_last_vec   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_tag      <= w_in_tag;
        r_idx      <= w_in_idx;
        r_word     <= bus.addr[3:2];
        r_wdata    <= bus.wdata;
        r_vec      <= bus.vec_mode;
        r_mask     <= bus.vec_mask;
        r_vwdata   <= bus.vec_wdata;
        r_is_write <= bus.write_enable;
        // forward a same-edge store so a back-to-back access sees new data
        if (w_wr_en && (r_idx == w_in_idx)) begin
          r_rd_tag  <= r_tag;
          r_rd_line <= w_wr_line;
        end else begin
          r_rd_tag  <= r_tag_mem[w_in_idx];
          r_rd_line <= r_data_mem[w_in_idx];
        end
      end else if (r_state == S_REFILL && bus.mem_ack) begin
        r_rd_tag  <= r_tag;
        r_rd_line <= w_wr_line;
      end
      if (w_wr_en) begin
        r_valid[r_idx] <= 1'b1;
        r_dirty[r_idx] <= r_is_write;
      end else if (r_state == S_WRITEBACK && bus.mem_ack) begin
        r_dirty[r_idx] <= 1'b0;
      end
      if (w_load) begin
        r_last_rdata <= w_word_out;
        r_last_vec   <= r_rd_line;
      end
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder; the bench plays both the memory stage
// and DRAM, acknowledging line transfers by hand.
module tb_dcache_responder;
  logic clk;
  logic rstn;
  int unsigned n_tot;
  int unsigned n_bad;

  dcache_responder_if bus ();

  dcache_responder #(.INDEX_W(8), .ADDR_W(26)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  localparam logic [127:0] L1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] L1S = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'h11111111};
  localparam logic [127:0] L2 = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
  localparam logic [127:0] VW = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [127:0] VX = {32'h00000000, 32'hCCCC0002, 32'h00000000, 32'hAAAA0000};

  initial begin
    n_tot = 0;
    n_bad = 0;
    rstn = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.read_enable = 1'b0;
    bus.write_enable = 1'b0;
    bus.vec_mode = 1'b0;
    bus.vec_mask = '0;
    bus.vec_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ack = 1'b0;
    repeat (2) step();
    chk("rst_miss", bus.miss, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_vec", bus.vec_rdata, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    rstn = 1'b1;
    step();

    // cold load miss and refill
    bus.addr = 32'h100; bus.read_enable = 1'b1;
    step();
    bus.read_enable = 1'b0;
    chk("t1_miss_cmp", bus.miss, 1);
    chk("t1_noreq_cmp", bus.mem_req, 0);
    step();
    chk("t1_req", bus.mem_req, 1);
    chk("t1_we", bus.mem_we, 0);
    chk("t1_maddr", bus.mem_addr, 32'h100);
    chk("t1_miss_ref", bus.miss, 1);
    bus.mem_rdata = L1; bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("t1_rdata", bus.rdata, 32'h11111111);
    chk("t1_miss_resp", bus.miss, 0);
    chk("t1_req_drop", bus.mem_req, 0);

    // store hit followed immediately by load of the same word
    bus.addr = 32'h104; bus.wdata = 32'hDEADBEEF; bus.write_enable = 1'b1;
    step();
    chk("t2_st_miss", bus.miss, 0);
    bus.write_enable = 1'b0; bus.read_enable = 1'b1;
    step();
    bus.read_enable = 1'b0;
    chk("t2_ld_rdata", bus.rdata, 32'hDEADBEEF);
    chk("t2_ld_miss", bus.miss, 0);
    chk("t2_noreq", bus.mem_req, 0);
    step();
    chk("t2_hold", bus.rdata, 32'hDEADBEEF);

    // back-to-back hit loads
    bus.addr = 32'h100; bus.read_enable = 1'b1;
    step();
    chk("t5_miss0", bus.miss, 0);
    chk("t5_w0", bus.rdata, 32'h11111111);
    bus.addr = 32'h108;
    step();
    chk("t5_miss1", bus.miss, 0);
    chk("t5_w2", bus.rdata, 32'h33333333);
    bus.addr = 32'h10C;
    step();
    chk("t5_miss2", bus.miss, 0);
    chk("t5_w3", bus.rdata, 32'h44444444);
    chk("t5_vec", bus.vec_rdata, L1S);
    bus.read_enable = 1'b0;
    step();

    // conflict miss on a dirty line: writeback then refill
    bus.addr = 32'h1100; bus.read_enable = 1'b1;
    step();
    bus.read_enable = 1'b0;
    chk("t3_miss", bus.miss, 1);
    step();
    chk("t3_wb_req", bus.mem_req, 1);
    chk("t3_wb_we", bus.mem_we, 1);
    chk("t3_wb_addr", bus.mem_addr, 32'h100);
    chk("t3_wb_word1", bus.mem_wdata[63:32], 32'hDEADBEEF);
    chk("t3_wb_line", bus.mem_wdata, L1S);
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("t3_rf_req", bus.mem_req, 1);
    chk("t3_rf_we", bus.mem_we, 0);
    chk("t3_rf_addr", bus.mem_addr, 32'h1100);
    chk("t3_rf_miss", bus.miss, 1);
    bus.mem_rdata = L2; bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("t3_rdata", bus.rdata, 32'h0A0A0A0A);
    chk("t3_miss0", bus.miss, 0);
    step();

    // masked vector store-allocate over a zero line, then vector load
    bus.addr = 32'h200; bus.vec_mode = 1'b1; bus.vec_mask = 4'b0101;
    bus.vec_wdata = VW; bus.write_enable = 1'b1;
    step();
    bus.write_enable = 1'b0;
    chk("t4_miss", bus.miss, 1);
    step();
    chk("t4_rf_addr", bus.mem_addr, 32'h200);
    chk("t4_rf_we", bus.mem_we, 0);
    bus.mem_rdata = '0; bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("t4_resp_miss", bus.miss, 0);
    chk("t4_rdata_hold", bus.rdata, 32'h0A0A0A0A);
    bus.read_enable = 1'b1;
    step();
    bus.read_enable = 1'b0;
    chk("t4_vld_miss", bus.miss, 0);
    chk("t4_vec", bus.vec_rdata, VX);
    bus.vec_mode = 1'b0;
    step();

    // address bits above ADDR_W do not take part in the tag
    bus.addr = 32'hFC000204; bus.read_enable = 1'b1;
    step();
    bus.read_enable = 1'b0;
    chk("hi_miss", bus.miss, 0);
    chk("hi_rdata", bus.rdata, 32'h0);
    step();

    // reset during refill
    bus.addr = 32'h300; bus.read_enable = 1'b1;
    step();
    bus.read_enable = 1'b0;
    step();
    chk("t6_req", bus.mem_req, 1);
    rstn = 1'b0;
    #1;
    chk("t6_req_drop", bus.mem_req, 0);
    chk("t6_miss_drop", bus.miss, 0);
    step();
    rstn = 1'b1;
    step();
    bus.addr = 32'h100; bus.read_enable = 1'b1;
    step();
    bus.read_enable = 1'b0;
    chk("t6_remiss", bus.miss, 1);
    step();
    chk("t6_rf_addr", bus.mem_addr, 32'h100);
    chk("t6_rf_req", bus.mem_req, 1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
